// File: rtl/gc.sv
// Global SUBLEQ core definitions: word/field layout, sequencer states
// and instruction field extractors shared by the core and its sequencer.
package gc;
    localparam int WORD_SIZE = 64;
    localparam int A_LB      = 0;
    localparam int A_UB      = 19;
    localparam int B_LB      = 20;
    localparam int B_UB      = 39;
    localparam int C_LB      = 40;
    localparam int C_UB      = 59;
    localparam int A_s       = A_UB - A_LB + 1;

    localparam logic [A_s-1:0] HALT_ADDR = 20'hFFFFF;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        FETCH_W = 4'd2,
        RD_A    = 4'd3,
        RD_A_W  = 4'd4,
        RD_B    = 4'd5,
        RD_B_W  = 4'd6,
        WRITE   = 4'd7,
        HALT    = 4'd8
    } ctrl_state_t;

    function automatic logic [A_s-1:0] arg_a(input logic [WORD_SIZE-1:0] w);
        return w[A_UB:A_LB];
    endfunction

    function automatic logic [A_s-1:0] arg_b(input logic [WORD_SIZE-1:0] w);
        return w[B_UB:B_LB];
    endfunction

    function automatic logic [A_s-1:0] arg_c(input logic [WORD_SIZE-1:0] w);
        return w[C_UB:C_LB];
    endfunction
endpackage

// File: rtl/urisc_subleq_alu.sv
// SUBLEQ arithmetic: wrapping B - A and the signed "result <= 0" branch test.
module urisc_subleq_alu
    import gc::*;
#(
    parameter int WORD_SIZE = gc::WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] i_op_a,
    input  logic [WORD_SIZE-1:0] i_op_b,
    output logic [WORD_SIZE-1:0] o_res,
    output logic                 o_leq
);
    logic [WORD_SIZE-1:0] w_res;

    assign w_res = i_op_b - i_op_a;
    assign o_res = w_res;
    assign o_leq = w_res[WORD_SIZE-1] | (w_res == {WORD_SIZE{1'b0}});
endmodule

// File: rtl/urisc_seq_ctrl.sv
// Multi-cycle SUBLEQ sequencer driving a single shared memory port:
// fetch, read mem[A], read mem[B], write mem[B]-mem[A], branch on result <= 0.
module urisc_seq_ctrl
    import gc::*;
#(
    parameter int                WORD_SIZE = gc::WORD_SIZE,
    parameter int                ADDR_W    = gc::A_s,
    parameter logic [ADDR_W-1:0] HALT_ADDR = gc::HALT_ADDR,
    parameter int                CNT_W     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_start_pc,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic [ADDR_W-1:0]    o_pc,
    output logic [CNT_W-1:0]     o_instr_count,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [WORD_SIZE-1:0] o_mem_wdata,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [WORD_SIZE-1:0] i_mem_rdata
);
    ctrl_state_t          r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [CNT_W-1:0]     r_instr_count;
    logic [WORD_SIZE-1:0] r_instr;
    logic [WORD_SIZE-1:0] r_op_a;
    logic [WORD_SIZE-1:0] r_op_b;
    logic                 r_busy;
    logic                 r_halted;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;

    logic [WORD_SIZE-1:0] w_res;
    logic                 w_leq;
    logic [ADDR_W-1:0]    w_arg_b;
    logic [ADDR_W-1:0]    w_arg_c;
    logic [ADDR_W-1:0]    w_next_pc;
    logic                 w_to_halt;

    urisc_subleq_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .i_op_a (r_op_a),
        .i_op_b (r_op_b),
        .o_res  (w_res),
        .o_leq  (w_leq)
    );

    assign w_arg_b   = arg_b(r_instr);
    assign w_arg_c   = arg_c(r_instr);
    assign w_next_pc = w_leq ? w_arg_c : (r_pc + ADDR_W'(1));
    assign w_to_halt = w_leq && (w_arg_c == HALT_ADDR);

    // Sequencer FSM; every request is set up one state early so req/addr/we come straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_pc          <= {ADDR_W{1'b0}};
            r_instr_count <= {CNT_W{1'b0}};
            r_instr       <= {WORD_SIZE{1'b0}};
            r_op_a        <= {WORD_SIZE{1'b0}};
            r_op_b        <= {WORD_SIZE{1'b0}};
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= {ADDR_W{1'b0}};
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (i_start) begin
                        r_state       <= FETCH;
                        r_pc          <= i_start_pc;
                        r_instr_count <= {CNT_W{1'b0}};
                        r_busy        <= 1'b1;
                        r_halted      <= 1'b0;
                        r_mem_req     <= 1'b1;
                        r_mem_we      <= 1'b0;
                        r_mem_addr    <= i_start_pc;
                    end
                end
                FETCH: begin
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= FETCH_W;
                    end
                end
                FETCH_W: begin
                    if (i_mem_rvalid) begin
                        r_instr    <= i_mem_rdata;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= arg_a(i_mem_rdata);
                        r_state    <= RD_A;
                    end
                end
                RD_A: begin
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RD_A_W;
                    end
                end
                RD_A_W: begin
                    if (i_mem_rvalid) begin
                        r_op_a     <= i_mem_rdata;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_arg_b;
                        r_state    <= RD_B;
                    end
                end
                RD_B: begin
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RD_B_W;
                    end
                end
                RD_B_W: begin
                    if (i_mem_rvalid) begin
                        r_op_b     <= i_mem_rdata;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_arg_b;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    // Retire; the next fetch is requested in the same edge unless the machine halts.
                    if (i_mem_gnt) begin
                        r_instr_count <= r_instr_count + CNT_W'(1);
                        r_pc          <= w_next_pc;
                        r_mem_we      <= 1'b0;
                        r_mem_addr    <= w_next_pc;
                        if (w_to_halt) begin
                            r_state   <= HALT;
                            r_mem_req <= 1'b0;
                            r_busy    <= 1'b0;
                            r_halted  <= 1'b1;
                        end else begin
                            r_state   <= FETCH;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_pc          = r_pc;
    assign o_instr_count = r_instr_count;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    // Write data is B - A of the operand flops, which only change while no write is pending.
    assign o_mem_wdata   = w_res;
endmodule

// File: tb/tb_urisc_seq_ctrl.sv
// Bench for urisc_seq_ctrl: behavioural memory with random stalls, a SUBLEQ
// reference model feeding a scoreboard of expected retirements.
module tb_urisc_seq_ctrl;
    localparam logic [19:0] HALT_PC = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] start_pc;
    logic        busy;
    logic        halted;
    logic [19:0] pc;
    logic [31:0] instr_count;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    urisc_seq_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_start_pc    (start_pc),
        .o_busy        (busy),
        .o_halted      (halted),
        .o_pc          (pc),
        .o_instr_count (instr_count),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_gnt     (mem_gnt),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata)
    );

    typedef struct packed {
        logic [19:0] waddr;
        logic [63:0] wdata;
        logic [19:0] pc;
        logic [31:0] cnt;
    } exp_t;

    int          n_err = 0;
    int          n_chk = 0;
    logic [63:0] mem [logic [19:0]];
    logic [63:0] sh  [logic [19:0]];
    exp_t        exp_q[$];
    int          max_stall = 0;
    int          max_lat   = 1;
    bit          block_wr  = 1'b0;
    logic [19:0] last_waddr = 20'd0;
    logic [63:0] last_wdata = 64'd0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_mem(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    function automatic logic [63:0] rd_sh(input logic [19:0] a);
        return sh.exists(a) ? sh[a] : 64'd0;
    endfunction

    function automatic logic [63:0] ins(input logic [19:0] c, input logic [19:0] b, input logic [19:0] a);
        return {4'h0, c, b, a};
    endfunction

    // Reference SUBLEQ interpreter on a shadow copy of memory; queues one entry per retirement.
    task automatic model_run(input logic [19:0] spc);
        logic [19:0] p;
        logic [19:0] nxt;
        logic [63:0] iw;
        logic [63:0] r;
        logic        taken;
        exp_t        e;
        p  = spc;
        sh = mem;
        for (int n = 1; n <= 64; n++) begin
            iw    = rd_sh(p);
            r     = rd_sh(iw[39:20]) - rd_sh(iw[19:0]);
            sh[iw[39:20]] = r;
            taken = ($signed(r) <= 64'sd0);
            nxt   = taken ? iw[59:40] : p + 20'd1;
            e.waddr = iw[39:20];
            e.wdata = r;
            e.pc    = nxt;
            e.cnt   = 32'(n);
            exp_q.push_back(e);
            if (taken && (iw[59:40] == HALT_PC)) break;
            p = nxt;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [19:0] spc);
        start_pc = spc;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int c = 0;
        while (!halted && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, halted, 1'b1);
        tick(2);
    endtask

    // Memory responder, handshake-stability monitor and retirement scoreboard.
    initial begin : mem_model
        bit          pend      = 1'b0;
        int          pend_cnt  = 0;
        logic [63:0] pend_data = 64'd0;
        bit          armed     = 1'b0;
        int          stall     = 0;
        bit          stalled   = 1'b0;
        logic [85:0] held      = 86'd0;
        logic [31:0] prev_cnt  = 32'd0;
        exp_t        e;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'd0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (rst) begin
                pend    = 1'b0;
                armed   = 1'b0;
                stalled = 1'b0;
            end else begin
                if (instr_count == prev_cnt + 32'd1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", instr_count, prev_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", last_waddr, e.waddr);
                        chk("wr_data", last_wdata, e.wdata);
                        chk("retire_pc", pc, e.pc);
                        chk("retire_cnt", instr_count, e.cnt);
                    end
                end
                chk("busy_halted_excl", busy & halted, 1'b0);
                if (stalled) chk("req_hold", {mem_req, mem_we, mem_addr, mem_wdata}, held);
                if (pend) begin
                    if (pend_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = pend_data;
                        pend       = 1'b0;
                    end else begin
                        pend_cnt--;
                    end
                end
                if (mem_req && !(mem_we && block_wr)) begin
                    if (!armed) begin
                        armed = 1'b1;
                        stall = $urandom_range(max_stall, 0);
                    end
                    if (stall == 0) begin
                        mem_gnt = 1'b1;
                        armed   = 1'b0;
                        if (mem_we) begin
                            mem[mem_addr] = mem_wdata;
                            last_waddr    = mem_addr;
                            last_wdata    = mem_wdata;
                        end else begin
                            pend      = 1'b1;
                            pend_cnt  = $urandom_range(max_lat, 1) - 1;
                            pend_data = rd_mem(mem_addr);
                        end
                    end else begin
                        stall--;
                    end
                end
                stalled = mem_req && !mem_gnt;
                held    = {mem_req, mem_we, mem_addr, mem_wdata};
            end
            prev_cnt = instr_count;
        end
    end

    initial begin : stim
        int c;
        int reqs;
        int pc_bad;
        rst      = 1'b1;
        start    = 1'b0;
        start_pc = 20'd0;
        tick(2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", pc, 20'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 20'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        rst = 1'b0;
        tick(1);

        // Reset while a write is stalled
        mem.delete();
        mem[20'd0]  = ins(20'd5, 20'd11, 20'd10);
        mem[20'd10] = 64'd3;
        mem[20'd11] = 64'd7;
        block_wr = 1'b1;
        go(20'd0);
        c = 0;
        while (!(mem_req && mem_we) && c < 50) begin
            tick(1);
            c++;
        end
        chk("reach_write", mem_req & mem_we, 1'b1);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("midrst_req", mem_req, 1'b0);
        chk("midrst_pc", pc, 20'd0);
        chk("midrst_cnt", instr_count, 32'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_halted", halted, 1'b0);
        rst      = 1'b0;
        block_wr = 1'b0;
        tick(2);

        // Single non-taken instruction, zero-wait memory, 7-cycle latency
        mem.delete();
        mem[20'd0]  = ins(20'd5, 20'd11, 20'd10);
        mem[20'd1]  = ins(HALT_PC, 20'd20, 20'd20);
        mem[20'd10] = 64'd3;
        mem[20'd11] = 64'd7;
        mem[20'd20] = 64'd1;
        model_run(20'd0);
        go(20'd0);
        c = 0;
        while (instr_count == 32'd0 && c < 50) begin
            tick(1);
            c++;
        end
        chk("instr_cycles", c, 7);
        chk("first_pc", pc, 20'd1);
        wait_halt(100, "t2_halt");
        chk("t2_mem11", rd_mem(20'd11), 64'd4);

        // Taken branches: zero result, then wrapped negative result, then halt
        mem.delete();
        mem[20'd0]  = ins(20'd5, 20'd11, 20'd10);
        mem[20'd5]  = ins(20'd8, 20'd13, 20'd12);
        mem[20'd8]  = ins(HALT_PC, 20'd14, 20'd14);
        mem[20'd10] = 64'd7;
        mem[20'd11] = 64'd7;
        mem[20'd12] = 64'h8000_0000_0000_0000;
        mem[20'd13] = 64'd5;
        mem[20'd14] = 64'd9;
        model_run(20'd0);
        go(20'd0);
        wait_halt(200, "t3_halt");
        chk("t3_mem11", rd_mem(20'd11), 64'd0);
        chk("t3_mem13", rd_mem(20'd13), 64'h8000_0000_0000_0005);
        chk("t3_busy", busy, 1'b0);
        chk("t3_pc", pc, HALT_PC);

        // Halt holds for 100 cycles, then restart from pc 2
        reqs   = 0;
        pc_bad = 0;
        repeat (100) begin
            tick(1);
            if (mem_req) reqs++;
            if (pc != HALT_PC) pc_bad++;
        end
        chk("halt_no_req", reqs, 0);
        chk("halt_pc_hold", pc_bad, 0);
        mem[20'd2] = ins(20'd9, 20'd13, 20'd10);
        mem[20'd3] = ins(HALT_PC, 20'd14, 20'd14);
        model_run(20'd2);
        go(20'd2);
        chk("restart_busy", busy, 1'b1);
        wait_halt(200, "t4_halt");
        chk("t4_mem13", rd_mem(20'd13), 64'h7FFF_FFFF_FFFF_FFFE);

        // Random grant stalls and read latencies on a 3-instruction program
        max_stall = 5;
        max_lat   = 6;
        mem.delete();
        mem[20'd0]  = ins(20'd7, 20'd21, 20'd20);
        mem[20'd1]  = ins(20'd4, 20'd22, 20'd21);
        mem[20'd4]  = ins(HALT_PC, 20'd23, 20'd23);
        mem[20'd20] = 64'd2;
        mem[20'd21] = 64'd10;
        mem[20'd22] = 64'd3;
        mem[20'd23] = 64'd6;
        model_run(20'd0);
        go(20'd0);
        wait_halt(2000, "t5_halt");
        chk("t5_cnt", instr_count, 32'd3);
        foreach (sh[k]) chk("t5_final_mem", rd_mem(k), sh[k]);
        max_stall = 0;
        max_lat   = 1;

        // pc wrap FFFFE -> FFFFF -> 0, with an ignored start while busy
        mem.delete();
        mem[20'hFFFFE] = ins(20'd5, 20'd31, 20'd30);
        mem[20'hFFFFF] = ins(20'd5, 20'd31, 20'd30);
        mem[20'd0]     = ins(HALT_PC, 20'd32, 20'd32);
        mem[20'd30]    = 64'd1;
        mem[20'd31]    = 64'd100;
        model_run(20'hFFFFE);
        go(20'hFFFFE);
        tick(3);
        go(20'd7);
        wait_halt(300, "t6_halt");
        chk("t6_cnt", instr_count, 32'd3);
        chk("t6_mem31", rd_mem(20'd31), 64'd98);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/urisc_seq_ctrl.md
Name: urisc_seq_ctrl

Overview:
- Multi-cycle sequencer for the SUBLEQ datapath: fetches a 64-bit instruction word, reads mem[A] and mem[B], writes mem[B] - mem[A] back to B, then branches to C if the result is <= 0.
- Sits between the top-level core and a single shared memory port.
- Uses the global field layout: A = bits [19:0], B = [39:20], C = [59:40]; bits [63:60] are ignored.

Parameters:
- WORD_SIZE, 64, data/instruction word width (gc::WORD_SIZE)
- ADDR_W, 20, address/argument width (gc::A_s)
- HALT_ADDR, 20'hFFFFF, branch target that halts the machine
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins execution from start_pc (honoured only in IDLE or HALT)
- start_pc  in  ADDR_W  initial program counter
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- pc  out  ADDR_W  current program counter
- instr_count  out  CNT_W  retired instructions since last start
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  WORD_SIZE  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WORD_SIZE  read data

Behaviour:
- Reset (synchronous, active-high) values: state = IDLE, pc = 0, instr_count = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, halted = 0. Internal regs: instr, opA, opB = 0.
- Reset asserted mid-operation aborts immediately. Any outstanding read response is ignored; the memory side must also be reset.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the cycle mem_gnt = 1.
  - mem_req deasserts the cycle after grant.
  - At most one read outstanding; read data arrives on mem_rvalid, at least 1 cycle after grant.
  - mem_rvalid while not in a *_W state is ignored.
  - Writes complete on grant.
- States and transitions:
  - IDLE: on start, pc <= start_pc, instr_count <= 0, go to FETCH.
  - FETCH: req read @pc; on gnt go to FETCH_W.
  - FETCH_W: on rvalid, instr <= rdata, go to RD_A.
  - RD_A: req read @instr.A; on gnt go to RD_A_W.
  - RD_A_W: on rvalid, opA <= rdata, go to RD_B.
  - RD_B: req read @instr.B; on gnt go to RD_B_W.
  - RD_B_W: on rvalid, opB <= rdata, go to WRITE.
  - WRITE: req write @instr.B with data res = opB - opA. On gnt:
    - instr_count <= instr_count + 1
    - pc <= (res signed <= 0) ? instr.C : pc + 1
    - go to HALT if the branch is taken and instr.C == HALT_ADDR; else FETCH.
  - HALT: hold all state; on start, behave as IDLE+start.
- Arithmetic:
  - res is WORD_SIZE two's-complement subtraction, wrapping with no overflow flag.
  - The <= 0 test uses the signed interpretation of the wrapped result.
  - pc + 1 wraps 20'hFFFFF to 0.
  - instr_count wraps at 2^CNT_W.
- Aliasing: when A == B, both reads are still performed, so res = 0 and the branch is always taken. When the write targets the instruction's own address, the next fetch observes the new word.
- Timing: 4 memory transactions per instruction. With 1-cycle grant and 1-cycle read latency, an instruction takes 7 cycles.
- start while busy is ignored.
- halted and busy are never both high.

Decomposition:
- Add to package gc:
  - ctrl_state_t enum (IDLE, FETCH, FETCH_W, RD_A, RD_A_W, RD_B, RD_B_W, WRITE, HALT)
  - HALT_ADDR constant
  - field-extract helper functions arg_a/arg_b/arg_c(word) built from the existing *_LB/*_UB constants.
- One natural sub-module: urisc_subleq_alu. Purely combinational; inputs opA, opB; outputs res and leq (signed res <= 0).

Test Plan:
- Reset mid-WRITE (mem_gnt held 0) → next cycle: state IDLE, mem_req 0, pc 0, instr_count 0, busy 0.
- Memory mem[0] = {C=5, B=11, A=10}, mem[10] = 3, mem[11] = 7, start_pc = 0 → mem[11] = 4, pc = 1, instr_count = 1; 7 cycles with zero-wait memory.
- mem[10] = 7, mem[11] = 7 → mem[11] = 0, branch taken, pc = 5. Then with mem[11] = 5 and mem[10] = 64'h8000_0000_0000_0000 → wrapped result is negative, branch taken.
- Instruction with C = 20'hFFFFF and A == B → halted = 1, busy = 0. pc stays 20'hFFFFF for 100 cycles with no mem_req. A new start with start_pc = 2 resumes execution.
- Random mem_gnt stalls (0–5 cycles) and rvalid delays (1–6 cycles) on a 3-instruction program → identical final memory and instr_count = 3. mem_addr/mem_we/mem_wdata stay stable while mem_req & !mem_gnt.
- pc = 20'hFFFFE with non-taken branches → pc goes FFFFF, then 0 (wrap); start pulsed while busy has no effect.
